dcache_ctrl: RTL

DCACHE_CTRL -- requirements
Module: dcache_ctrl

---
 rtl/dcache_ctrl.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/dcache_ctrl.sv
// -----------------------------------------------------------------------------
// dcache_ctrl
//   Direct-mapped, write-back, write-allocate data cache controller.
//   Geometry: 32 lines x 4 words x 16 bits, 16-bit byte address.
//   Address split: tag [15:8], index [7:3], word [2:1], byte [0] (must be 0).
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   Addr       in   byte address of the access
//   DataIn     in   store data
//   Rd / Wr    in   load / store request, held until Done
//   DataOut    out  load data, valid while Done=1 for a load
//   Done       out  one-cycle completion pulse
//   Stall      out  miss in progress
//   CacheHit   out  access completed without memory traffic
//   Err        out  illegal request (odd address or Rd and Wr together)
//   mem_req    out  backing-memory word request, held until mem_ack
//   mem_wr     out  1 = write, 0 = read
//   mem_addr   out  word-aligned backing-memory byte address
//   mem_wdata  out  backing-memory write data
//   mem_rdata  in   backing-memory read data, valid with mem_ack
//   mem_ack    in   one-cycle completion pulse from backing memory
// -----------------------------------------------------------------------------
module dcache_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] Addr,
   input  logic [15:0] DataIn,
   input  logic        Rd,
   input  logic        Wr,
   output logic [15:0] DataOut,
   output logic        Done,
   output logic        Stall,
   output logic        CacheHit,
   output logic        Err,
   output logic        mem_req,
   output logic        mem_wr,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   input  logic        mem_ack
);

   typedef enum logic [1:0] {S_IDLE, S_WB, S_FILL, S_DONE} state_t;

   state_t      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;          // word counter for WB/FILL bursts
   logic        gap_q, gap_d;          // forces one idle cycle after each ack
   logic [15:1] req_addr_q, req_addr_d;
   logic [15:0] req_data_q, req_data_d;
   logic        req_wr_q, req_wr_d;

   logic [15:0] data_mem [0:31][0:3];
   logic [7:0]  tag_mem  [0:31];
   logic [31:0] valid_q;
   logic [31:0] dirty_q;

   // Incoming request fields
   logic [7:0] in_tag;
   logic [4:0] in_idx;
   logic [1:0] in_word;
   assign in_tag  = Addr[15:8];
   assign in_idx  = Addr[7:3];
   assign in_word = Addr[2:1];

   // Latched (miss) request fields
   logic [7:0] r_tag;
   logic [4:0] r_idx;
   logic [1:0] r_word;
   assign r_tag  = req_addr_q[15:8];
   assign r_idx  = req_addr_q[7:3];
   assign r_word = req_addr_q[2:1];

   logic req_any, illegal, hit;
   assign req_any = Rd | Wr;
   assign illegal = req_any & (Addr[0] | (Rd & Wr));
   assign hit     = req_any & ~illegal & valid_q[in_idx] & (tag_mem[in_idx] == in_tag);

   // Array write enables, decoded by the FSM and consumed by the storage block
   logic hit_wr, done_wr, fill_we, fill_last;

   // NOTE: every signal written here gets a default first, so no path leaves a
   // value held and no latch is inferred.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      gap_d      = 1'b0;
      req_addr_d = req_addr_q;
      req_data_d = req_data_q;
      req_wr_d   = req_wr_q;
      DataOut    = 16'h0000;
      Done       = 1'b0;
      Stall      = 1'b0;
      CacheHit   = 1'b0;
      Err        = 1'b0;
      mem_req    = 1'b0;
      mem_wr     = 1'b0;
      mem_addr   = 16'h0000;
      mem_wdata  = 16'h0000;
      hit_wr     = 1'b0;
      done_wr    = 1'b0;
      fill_we    = 1'b0;
      fill_last  = 1'b0;

      // Outputs are forced quiet while reset is held, so an aborted burst
      // drops mem_req without waiting for a clock.
      if (!rst) begin
         unique case (state_q)
            S_IDLE: begin
               if (illegal) begin
                  Done = 1'b1;
                  Err  = 1'b1;
               end else if (hit) begin
                  Done     = 1'b1;
                  CacheHit = 1'b1;
                  if (Rd) DataOut = data_mem[in_idx][in_word];
                  hit_wr   = Wr;
               end else if (req_any) begin
                  Stall      = 1'b1;
                  req_addr_d = Addr[15:1];
                  req_data_d = DataIn;
                  req_wr_d   = Wr;
                  cnt_d      = 2'd0;
                  state_d    = (valid_q[in_idx] && dirty_q[in_idx]) ? S_WB : S_FILL;
               end
            end

            S_WB: begin
               Stall     = 1'b1;
               mem_req   = ~gap_q;
               mem_wr    = 1'b1;
               mem_addr  = {tag_mem[r_idx], r_idx, cnt_q, 1'b0};
               mem_wdata = data_mem[r_idx][cnt_q];
               if (mem_ack && !gap_q) begin
                  cnt_d = cnt_q + 2'd1;   // wraps 3 -> 0 on the way into FILL
                  gap_d = 1'b1;
                  if (cnt_q == 2'd3) state_d = S_FILL;
               end
            end

            S_FILL: begin
               Stall    = 1'b1;
               mem_req  = ~gap_q;
               mem_addr = {r_tag, r_idx, cnt_q, 1'b0};
               if (mem_ack && !gap_q) begin
                  fill_we = 1'b1;
                  cnt_d   = cnt_q + 2'd1;
                  gap_d   = 1'b1;
                  if (cnt_q == 2'd3) begin
                     fill_last = 1'b1;
                     state_d   = S_DONE;
                  end
               end
            end

            S_DONE: begin
               Done    = 1'b1;
               Stall   = 1'b1;
               if (!req_wr_q) DataOut = data_mem[r_idx][r_word];
               done_wr = req_wr_q;
               state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= 2'd0;
         gap_q      <= 1'b0;
         req_addr_q <= '0;
         req_data_q <= 16'h0000;
         req_wr_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         gap_q      <= gap_d;
         req_addr_q <= req_addr_d;
         req_data_q <= req_data_d;
         req_wr_q   <= req_wr_d;
      end
   end

   // Line status bits: cleared by reset so every line starts invalid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else begin
         if (hit_wr)  dirty_q[in_idx] <= 1'b1;
         if (done_wr) dirty_q[r_idx]  <= 1'b1;
         if (fill_last) begin
            valid_q[r_idx] <= 1'b1;
            dirty_q[r_idx] <= 1'b0;
         end
      end
   end

   // NOTE: data and tag arrays have no reset; the valid bits already make any
   // stale contents unreachable, and leaving them unreset keeps them RAM-mappable.
   always_ff @(posedge clk) begin
      if (hit_wr)    data_mem[in_idx][in_word] <= DataIn;
      if (done_wr)   data_mem[r_idx][r_word]   <= req_data_q;
      if (fill_we)   data_mem[r_idx][cnt_q]    <= mem_rdata;
      if (fill_last) tag_mem[r_idx]            <= r_tag;
   end

endmodule
